// File: rtl/libv_pkg.sv
// Shared helpers for the queue scheduler: queue-index width and one-hot to index conversion.
// Pure combinational; no state, no backpressure.
package libv_pkg;

  localparam int QIDX_W = 4;
  localparam int OHW    = 1 << QIDX_W;

  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // OR-reduction form keeps this a flat mux tree for any one-hot input.
  function automatic logic [QIDX_W-1:0] onehot_to_idx(input logic [OHW-1:0] oh);
    logic [QIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < OHW; i++) begin
      if (oh[i]) idx = idx | QIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo.sv
// Basic FIFO, depth N: pop_data is combinational from the head entry, flags come from registered state.
// Push while full is dropped, pop while empty is ignored; flush empties it next cycle.
module fifo #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] pop_data,
  output logic         empty_r,
  output logic         full_r
);
  localparam int AW = $clog2(N);

  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign empty_r  = (count_q == '0);
  assign full_r   = (count_q == (AW+1)'(N));
  assign push_en  = push & ~full_r;
  assign pop_en   = pop & ~empty_r;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/queue_rr_sched_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting after last_grant, state moves only on upd.
// Zero-cycle grant; caller decides when a grant is consumed via upd.
module rr_arb
  import libv_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         upd,
  input  logic [M-1:0] req,
  output logic [M-1:0] grant
);
  localparam int IW = idx_w(M);

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          found;

  // First pass covers indices above last_grant, the wrap pass covers 0..last_grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (!found && req[i] && (i > int'(last_grant_q))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < M; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (upd)   last_grant_d = IW'(onehot_to_idx(OHW'(grant)));
    if (flush) last_grant_d = IW'(M - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= IW'(M - 1);
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/queue_rr_sched.sv
// M input FIFOs drained round-robin into one registered output stage; push to out_valid is 2 cycles.
// Output holds while out_ready is low; full queues deassert in_ready and drop further pushes.
module queue_rr_sched
  import libv_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         in_valid,
  input  logic [M*W-1:0]       in_data,
  output logic [M-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [idx_w(M)-1:0]  out_id,
  input  logic                 out_ready,
  input  logic                 flush
);
  localparam int IW = idx_w(M);

  logic [M-1:0]  empty, full, pop, grant;
  logic [W-1:0]  pop_data [M];
  logic [W-1:0]  sel_data;
  logic          load;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] out_id_q, out_id_d;

  for (genvar g = 0; g < M; g++) begin : g_queue
    fifo #(.W(W), .N(N)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[g]),
      .push_data (in_data[g*W +: W]),
      .pop       (pop[g]),
      .flush     (flush),
      .pop_data  (pop_data[g]),
      .empty_r   (empty[g]),
      .full_r    (full[g])
    );
  end

  rr_arb #(.M(M)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .upd   (load),
    .req   (~empty),
    .grant (grant)
  );

  assign load     = ~flush & (~out_valid_q | out_ready) & (|(~empty));
  assign pop      = grant & {M{load}};
  assign in_ready = ~full;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < M; i++) begin
      if (grant[i]) sel_data = sel_data | pop_data[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_id_d    = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_id_d    = IW'(onehot_to_idx(OHW'(grant)));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_queue_rr_sched.sv
// Bench for queue_rr_sched: directed scenarios plus random traffic against a queue-level reference model.
module tb_queue_rr_sched;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst, flush, out_ready;
  logic [M-1:0]   in_valid;
  logic [M*W-1:0] in_data;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;

  always #5 clk = ~clk;

  queue_rr_sched #(.W(W), .N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .flush     (flush)
  );

  // Reference model: one SV queue per input queue plus the output stage.
  logic [W-1:0] mq [M][$];
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_oid;
  int           m_last;
  logic [M-1:0] m_rdy;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;

  // Advance one clock: model consumes the inputs applied this cycle; returns at the falling edge.
  task automatic tick();
    int           g;
    int           c;
    logic [M-1:0] full_pre;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < M; i++) mq[i].delete();
      m_ov = 0; m_od = '0; m_oid = 0; m_last = M - 1;
    end else if (flush) begin
      for (int i = 0; i < M; i++) mq[i].delete();
      m_ov = 0; m_last = M - 1;
    end else begin
      g = -1;
      for (int i = 0; i < M; i++) full_pre[i] = (mq[i].size() >= N);
      if (!m_ov || out_ready) begin
        for (int k = 1; k <= M; k++) begin
          c = (m_last + k) % M;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
      end
      if (g >= 0) begin
        m_od = mq[g].pop_front(); m_ov = 1; m_oid = g; m_last = g;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      for (int i = 0; i < M; i++)
        if (in_valid[i] && !full_pre[i]) mq[i].push_back(in_data[i*W +: W]);
    end
    for (int i = 0; i < M; i++) m_rdy[i] = (mq[i].size() < N);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = '0; in_data = '0; out_ready = 0;
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || in_ready !== '1) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%h id=%0d rdy=%b, want v=0 d=0000 id=0 rdy=1111",
               out_valid, out_data, out_id, in_ready);
    end
    rst = 0;
  endtask

  task automatic test_latency();
    in_valid = 4'b0100; in_data = '0; in_data[2*W +: W] = 16'h00A0; out_ready = 1;
    tick();
    in_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_c1: got v=%b, want v=0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A0 || out_id !== 2'd2) begin
      n_err++;
      $display("FAIL latency_c2: got v=%b d=%h id=%0d, want v=1 d=00a0 id=2", out_valid, out_data, out_id);
    end
    tick();
    n_cmp++;
    if (out_valid !== m_ov || in_ready !== m_rdy) begin
      n_err++; $display("FAIL latency_drain: got v=%b rdy=%b, want v=%b rdy=%b", out_valid, in_ready, m_ov, m_rdy);
    end
  endtask

  task automatic test_order4();
    flush = 1; tick(); flush = 0;
    out_ready = 1; in_valid = '1;
    for (int i = 0; i < M; i++) in_data[i*W +: W] = W'(16'h10 + i);
    tick();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== IW'(k) || out_data !== W'(16'h10 + k)) begin
        n_err++;
        $display("FAIL order4[%0d]: got v=%b d=%h id=%0d, want v=1 d=%h id=%0d",
                 k, out_valid, out_data, out_id, W'(16'h10 + k), k);
      end
    end
  endtask

  task automatic test_rr_1_3();
    int exp_id [6] = '{1, 3, 1, 3, 1, 3};
    logic [W-1:0] exp_d;
    flush = 1; tick(); flush = 0;
    out_ready = 0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'b1010; in_data = '0;
      in_data[1*W +: W] = W'(16'h100 + j);
      in_data[3*W +: W] = W'(16'h300 + j);
      tick();
    end
    in_valid = '0; out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      exp_d = W'(((exp_id[k] == 1) ? 16'h100 : 16'h300) + k / 2);
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== IW'(exp_id[k]) || out_data !== exp_d) begin
        n_err++;
        $display("FAIL rr13[%0d]: got v=%b d=%h id=%0d, want v=1 d=%h id=%0d",
                 k, out_valid, out_data, out_id, exp_d, exp_id[k]);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    out_ready = 0; in_valid = 4'b0101; in_data = '0;
    in_data[0*W +: W] = 16'hBEE0; in_data[2*W +: W] = 16'hBEE2;
    tick();
    in_valid = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEE0 || out_id !== 2'd0 || in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b d=%h id=%0d rdy=%b, want v=1 d=bee0 id=0 rdy=%b",
                 k, out_valid, out_data, out_id, in_ready, m_rdy);
      end
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== m_ov || in_ready !== m_rdy || (m_ov && (out_data !== m_od || out_id !== IW'(m_oid)))) begin
        n_err++;
        $display("FAIL hold_drain cyc %0d: got v=%b d=%h id=%0d rdy=%b, want v=%b d=%h id=%0d rdy=%b",
                 cyc, out_valid, out_data, out_id, in_ready, m_ov, m_od, m_oid, m_rdy);
      end
    end
  endtask

  task automatic test_overflow();
    int nout;
    flush = 1; tick(); flush = 0;
    out_ready = 0;
    for (int j = 0; j < N + 2; j++) begin
      in_valid = 4'b0001; in_data = '0; in_data[0 +: W] = W'(16'hC000 + j);
      tick();
      n_cmp++;
      if (out_valid !== m_ov || in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL overflow_fill[%0d]: got v=%b rdy=%b, want v=%b rdy=%b", j, out_valid, in_ready, m_ov, m_rdy);
      end
    end
    in_valid = '0;
    n_cmp++;
    if (in_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL overflow_full: got in_ready[0]=%b, want 0", in_ready[0]);
    end
    out_ready = 1; nout = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (out_data !== W'(16'hC000 + nout) || out_id !== 2'd0) begin
          n_err++;
          $display("FAIL overflow_seq[%0d]: got d=%h id=%0d, want d=%h id=0", nout, out_data, out_id, W'(16'hC000 + nout));
        end
        nout++;
      end
      tick();
    end
    n_cmp++;
    if (nout != N + 1) begin
      n_err++; $display("FAIL overflow_count: got %0d outputs, want %0d", nout, N + 1);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int j = 0; j < 2; j++) begin
      in_valid = '1;
      for (int i = 0; i < M; i++) in_data[i*W +: W] = W'(16'hD000 + 16 * i + j);
      tick();
    end
    in_valid = '0; tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: got v=%b, want v=1", out_valid);
    end
    flush = 1; in_valid = '1; tick();
    flush = 0; in_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== '1) begin
      n_err++; $display("FAIL flush_post: got v=%b rdy=%b, want v=0 rdy=1111", out_valid, in_ready);
    end
    in_valid = 4'b1000; in_data[3*W +: W] = 16'h00F3; out_ready = 1;
    tick();
    in_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_lat_c1: got v=%b, want v=0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 16'h00F3) begin
      n_err++; $display("FAIL flush_lat_c2: got v=%b d=%h id=%0d, want v=1 d=00f3 id=3", out_valid, out_data, out_id);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 0; in_valid = '1;
    for (int i = 0; i < M; i++) in_data[i*W +: W] = W'(16'hE000 + i);
    tick(); tick(); tick();
    in_valid = '0; rst = 1; flush = 1; tick();
    rst = 0; flush = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || in_ready !== '1) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b d=%h id=%0d rdy=%b, want v=0 d=0000 id=0 rdy=1111",
               out_valid, out_data, out_id, in_ready);
    end
    out_ready = 1; tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_empty: got v=%b, want v=0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      in_valid = M'($urandom);
      for (int i = 0; i < M; i++) in_data[i*W +: W] = W'($urandom);
      out_ready = ((k % 64) < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 200) == 0);
      tick();
      n_cmp++;
      if (out_valid !== m_ov || in_ready !== m_rdy || (m_ov && (out_data !== m_od || out_id !== IW'(m_oid)))) begin
        n_err++;
        $display("FAIL random cyc %0d: got v=%b d=%h id=%0d rdy=%b, want v=%b d=%h id=%0d rdy=%b",
                 cyc, out_valid, out_data, out_id, in_ready, m_ov, m_od, m_oid, m_rdy);
      end
    end
    rst = 0; flush = 0; in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order4();
    test_rr_1_3();
    test_hold();
    test_overflow();
    test_flush();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
